// File: rtl/npu_mem_arbiter_pkg.sv
// Shared definitions for the CPU/NPU data-memory port arbiter.
// Holds the state encoding, default widths and the NOP data value.
package npu_mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_LEN_W      = 8;
    localparam int unsigned DEF_STARVE_LIM = 16;

    localparam int unsigned NOP_DATA = 0;

endpackage

// File: rtl/npu_mem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the NPU.
// CPU wins by default; the NPU gets counted exclusive bursts with a starvation bound.
module npu_mem_arbiter
    import npu_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              npu_req,
    input  logic [LEN_W-1:0]  npu_len,
    input  logic              npu_rd,
    input  logic              npu_wr,
    input  logic [ADDR_W-1:0] npu_addr,
    input  logic [DATA_W-1:0] npu_wd,
    output logic              npu_gnt,
    output logic [DATA_W-1:0] npu_rdata,
    output logic              npu_done,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    arb_state_t       state;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_q;
    logic [SW-1:0]    starve_cnt;

    logic cpu_act;
    logic npu_beat;
    logic go_burst;
    logic last_beat;
    logic in_burst;
    logic sel_rd;
    logic sel_wr;

    assign cpu_act   = cpu_rd | cpu_wr;
    assign npu_beat  = npu_rd | npu_wr;
    assign in_burst  = (state == ARB_BURST);
    assign go_burst  = npu_req && (!cpu_act || (32'(starve_cnt) >= STARVE_LIM - 1));
    // A dropped request on the would-be final beat is an abort, not a completion.
    assign last_beat = npu_req && npu_beat && (beat_cnt == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            beat_cnt   <= '0;
            len_q      <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (!npu_req) begin
                        starve_cnt <= '0;
                    end else if (go_burst) begin
                        state      <= ARB_BURST;
                        len_q      <= (npu_len == '0) ? LEN_W'(1) : npu_len;
                        beat_cnt   <= '0;
                        starve_cnt <= '0;
                    end else if (starve_cnt != '1) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                ARB_BURST: begin
                    if (!npu_req) begin
                        state <= ARB_IDLE;
                    end else if (npu_beat) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (last_beat) state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_rd    = cpu_rd;
        sel_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wd    = cpu_wd;
        cpu_rdata = mem_rdata;
        npu_rdata = DATA_W'(NOP_DATA);
        cpu_stall = 1'b0;
        if (in_burst) begin
            sel_rd    = npu_rd;
            sel_wr    = npu_wr;
            mem_addr  = npu_addr;
            mem_wd    = npu_wd;
            cpu_rdata = DATA_W'(NOP_DATA);
            npu_rdata = mem_rdata;
            cpu_stall = cpu_act;
        end
        // Enables are gated by the reset pin so memory stays quiet while it is held.
        mem_wr = rst && sel_wr;
        mem_rd = rst && sel_rd && !sel_wr;
    end

    assign npu_gnt  = in_burst;
    assign npu_done = in_burst && last_beat;

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Self-checking bench for npu_mem_arbiter: vector table, directed corner cases
// and randomized traffic against an ownership/beats-remaining reference model.
module tb_npu_mem_arbiter;
    import npu_mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned SL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_rd, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          npu_req;
    logic [LW-1:0] npu_len;
    logic          npu_rd, npu_wr;
    logic [AW-1:0] npu_addr;
    logic [DW-1:0] npu_wd;
    logic          npu_gnt;
    logic [DW-1:0] npu_rdata;
    logic          npu_done;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    npu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_LIM(SL)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .npu_req(npu_req), .npu_len(npu_len), .npu_rd(npu_rd), .npu_wr(npu_wr),
        .npu_addr(npu_addr), .npu_wd(npu_wd), .npu_gnt(npu_gnt),
        .npu_rdata(npu_rdata), .npu_done(npu_done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port, beats still owed, cycles waited.
    bit m_own  = 1'b0;
    int m_rem  = 0;
    int m_wait = 0;

    logic          s_gnt, s_stall, s_done, s_mrd, s_mwr;
    logic [AW-1:0] s_maddr;

    typedef struct {
        logic          rst, crd, cwr;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          nreq;
        logic [LW-1:0] nlen;
        logic          nrd, nwr;
        logic [AW-1:0] naddr;
        logic [DW-1:0] nwd, mrdata;
        logic          e_gnt, e_stall, e_done, e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_crd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic r, input logic crd, input logic cwr, input logic [AW-1:0] caddr,
        input logic [DW-1:0] cwd, input logic nreq, input logic [LW-1:0] nlen,
        input logic nrd, input logic nwr, input logic [AW-1:0] naddr,
        input logic [DW-1:0] nwd, input logic [DW-1:0] mrd,
        input logic eg, input logic es, input logic ed, input logic erd, input logic ewr,
        input logic [AW-1:0] eaddr, input logic [DW-1:0] ecrd);
        vec_t v;
        v.rst = r; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
        v.nreq = nreq; v.nlen = nlen; v.nrd = nrd; v.nwr = nwr; v.naddr = naddr;
        v.nwd = nwd; v.mrdata = mrd;
        v.e_gnt = eg; v.e_stall = es; v.e_done = ed; v.e_rd = erd; v.e_wr = ewr;
        v.e_addr = eaddr; v.e_crd = ecrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wd = '0;
        npu_req = 1'b0; npu_len = '0; npu_rd = 1'b0; npu_wr = 1'b0;
        npu_addr = '0; npu_wd = '0; mem_rdata = '0;
    endtask

    task automatic model_check();
        bit own, beat, cact;
        logic e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_crd, e_nrd;
        own  = rst && m_own;
        beat = npu_rd || npu_wr;
        cact = cpu_rd || cpu_wr;
        if (own) begin
            e_wr = npu_wr; e_rd = npu_rd && !npu_wr;
            e_addr = npu_addr; e_wd = npu_wd; e_crd = '0; e_nrd = mem_rdata;
        end else begin
            e_wr = cpu_wr; e_rd = cpu_rd && !cpu_wr;
            e_addr = cpu_addr; e_wd = cpu_wd; e_crd = mem_rdata; e_nrd = '0;
        end
        e_rd = e_rd && rst;
        e_wr = e_wr && rst;
        chk("npu_gnt",   npu_gnt,   own);
        chk("cpu_stall", cpu_stall, own && cact);
        chk("npu_done",  npu_done,  own && npu_req && beat && (m_rem == 1));
        chk("mem_rd",    mem_rd,    e_rd);
        chk("mem_wr",    mem_wr,    e_wr);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wd",    mem_wd,    e_wd);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("npu_rdata", npu_rdata, e_nrd);
        s_gnt = npu_gnt; s_stall = cpu_stall; s_done = npu_done;
        s_mrd = mem_rd; s_mwr = mem_wr; s_maddr = mem_addr;
    endtask

    task automatic model_update();
        bit beat, cact;
        beat = npu_rd || npu_wr;
        cact = cpu_rd || cpu_wr;
        if (!rst) begin
            m_own = 1'b0; m_wait = 0;
        end else if (!m_own) begin
            if (!npu_req) m_wait = 0;
            else if (!cact || (m_wait + 1 >= int'(SL))) begin
                m_own = 1'b1;
                m_rem = (npu_len == '0) ? 1 : int'(npu_len);
                m_wait = 0;
            end else m_wait++;
        end else begin
            if (!npu_req) m_own = 1'b0;
            else if (beat) begin
                m_rem--;
                if (m_rem == 0) m_own = 1'b0;
            end
        end
    endtask

    // Called at the negedge with inputs already driven.
    task automatic settle_step();
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        settle_step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;

        tbl.push_back(mk(0, 1, 1, 32'h10, 32'h55, 1, 3, 1, 1, 32'h200, 32'h66, 32'h77,
                         0, 0, 0, 0, 0, 32'h10, 32'h77));
        tbl.push_back(mk(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 32'h1234,
                         0, 0, 0, 1, 0, 32'h40, 32'h1234));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 1, 32'h100 + i, 32'hA0 + i, 32'hBEEF,
                             1, 0, (i == 3), 0, 1, 32'h100 + i, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; cpu_rd = tbl[i].crd; cpu_wr = tbl[i].cwr;
            cpu_addr = tbl[i].caddr; cpu_wd = tbl[i].cwd;
            npu_req = tbl[i].nreq; npu_len = tbl[i].nlen;
            npu_rd = tbl[i].nrd; npu_wr = tbl[i].nwr;
            npu_addr = tbl[i].naddr; npu_wd = tbl[i].nwd; mem_rdata = tbl[i].mrdata;
            #1;
            chk($sformatf("v%0d_gnt", i),   npu_gnt,   tbl[i].e_gnt);
            chk($sformatf("v%0d_stall", i), cpu_stall, tbl[i].e_stall);
            chk($sformatf("v%0d_done", i),  npu_done,  tbl[i].e_done);
            chk($sformatf("v%0d_mrd", i),   mem_rd,    tbl[i].e_rd);
            chk($sformatf("v%0d_mwr", i),   mem_wr,    tbl[i].e_wr);
            chk($sformatf("v%0d_maddr", i), mem_addr,  tbl[i].e_addr);
            chk($sformatf("v%0d_crd", i),   cpu_rdata, tbl[i].e_crd);
            settle_step();
        end

        // Starvation: back-to-back CPU stores hold off the NPU for STARVE_LIM cycles.
        idle_inputs();
        cpu_wr = 1'b1; npu_req = 1'b1; npu_len = 8'd2;
        begin
            int stores;
            stores = 0;
            for (int k = 0; k < 40; k++) begin
                cpu_addr = 32'h1000 + k; cpu_wd = k * 3;
                step();
                if (s_gnt) break;
                if (s_mwr && !s_stall) stores++;
            end
            chk("starve_grant_seen", s_gnt, 1);
            chk("starve_cpu_stores", stores, SL);
        end
        chk("starve_stall_in_burst", s_stall, 1);
        npu_wr = 1'b1; npu_addr = 32'h2000; npu_wd = 32'hD0;
        step();
        chk("starve_beat1_done", s_done, 0);
        npu_addr = 32'h2001;
        step();
        chk("starve_beat2_done", s_done, 1);
        chk("starve_beat2_stall", s_stall, 1);
        npu_wr = 1'b0; npu_req = 1'b0; cpu_addr = 32'h3333;
        step();
        chk("stalled_store_served", s_stall, 0);
        chk("stalled_store_wr", s_mwr, 1);
        chk("stalled_store_addr", s_maddr, 32'h3333);

        // Zero length behaves as a single beat.
        idle_inputs();
        npu_req = 1'b1; npu_len = '0;
        step();
        npu_rd = 1'b1; npu_addr = 32'h300;
        step();
        chk("len0_done", s_done, 1);
        chk("len0_gnt", s_gnt, 1);
        npu_rd = 1'b0;
        step();
        chk("len0_gnt_after", s_gnt, 0);
        npu_req = 1'b0;
        step();

        // Abort after 3 of 8 beats, then a fresh 2-beat burst must count from zero.
        idle_inputs();
        npu_req = 1'b1; npu_len = 8'd8;
        step();
        npu_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            npu_addr = 32'h400 + k;
            step();
            chk("abort_no_done", s_done, 0);
        end
        npu_req = 1'b0; npu_wr = 1'b0;
        step();
        chk("abort_cycle_gnt", s_gnt, 1);
        chk("abort_cycle_done", s_done, 0);
        step();
        chk("abort_idle_gnt", s_gnt, 0);
        npu_req = 1'b1; npu_len = 8'd2;
        step();
        npu_wr = 1'b1;
        step();
        chk("regrant_beat1_done", s_done, 0);
        step();
        chk("regrant_beat2_done", s_done, 1);
        npu_req = 1'b0; npu_wr = 1'b0;
        step();

        // Asynchronous reset on beat 2 of 5.
        idle_inputs();
        npu_req = 1'b1; npu_len = 8'd5;
        step();
        npu_wr = 1'b1; npu_addr = 32'h500;
        step();
        rst = 1'b0; npu_addr = 32'h501;
        step();
        chk("rst_mid_gnt", s_gnt, 0);
        chk("rst_mid_wr", s_mwr, 0);
        chk("rst_mid_done", s_done, 0);
        idle_inputs();
        cpu_rd = 1'b1; cpu_addr = 32'h44;
        step();
        chk("post_rst_stall", s_stall, 0);
        chk("post_rst_rd", s_mrd, 1);
        chk("post_rst_gnt", s_gnt, 0);

        // Randomized traffic; alternating windows of saturated CPU stores.
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) != 0);
            cpu_rd   = ($urandom_range(0, 2) == 0);
            cpu_wr   = ((i / 200) % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
            cpu_addr = $urandom; cpu_wd = $urandom;
            if ($urandom_range(0, 9) == 0) npu_req = ~npu_req;
            npu_len  = LW'($urandom_range(0, 6));
            npu_rd   = ($urandom_range(0, 4) < 2);
            npu_wr   = ($urandom_range(0, 4) < 2);
            npu_addr = $urandom; npu_wd = $urandom; mem_rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/npu_mem_arbiter.md
Name: npu_mem_arbiter

Overview:
- Shares the single data memory port between the pipelined CPU MEM stage and the NPU matrix engine.
- The CPU has priority by default. The NPU gets exclusive, counted bursts, and a starvation limit guarantees it is eventually granted.
- Memory is combinational-read and writes on the clock edge, so CPU accesses in IDLE complete with zero added latency.
- Sits between the CPU top level (memread/memwrite/addr/wd/R_DATA) and the data memory; stalls the CPU while the NPU owns the port.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
LEN_W, 8, width of NPU burst length field
STARVE_LIM, 16, max cycles npu_req may wait behind back-to-back CPU accesses

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
cpu_rd  in  1  CPU load request
cpu_wr  in  1  CPU store request
cpu_addr  in  ADDR_W  CPU address
cpu_wd  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  load data to MEM_WB
cpu_stall  out  1  hold CPU pipeline; access not performed this cycle
npu_req  in  1  NPU requests/holds ownership of the port
npu_len  in  LEN_W  burst beats, sampled when the grant decision is taken
npu_rd  in  1  NPU beat read
npu_wr  in  1  NPU beat write
npu_addr  in  ADDR_W  NPU beat address
npu_wd  in  DATA_W  NPU write data
npu_gnt  out  1  NPU owns the port
npu_rdata  out  DATA_W  read data to NPU
npu_done  out  1  one-cycle pulse on the final beat
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wd  out  DATA_W  memory write data
mem_rdata  in  DATA_W  combinational memory read data

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; beat_cnt, len_q and starve_cnt cleared.
  - npu_gnt=0, npu_done=0, cpu_stall=0.
  - mem_rd=mem_wr=0 forced while rst=0.
  - Reset mid-burst aborts the burst silently; no done pulse.
- cpu_act = cpu_rd|cpu_wr. If rd and wr are both asserted, write takes precedence and the access is a store. The same rule applies to the NPU.
- State IDLE:
  - mem_* muxed from the CPU; cpu_stall=0.
  - npu_gnt=0; npu_rdata=0.
  - starve_cnt increments (saturating) each cycle npu_req&&cpu_act; it clears when npu_req=0.
  - Go to BURST at the clock edge when npu_req && (!cpu_act || starve_cnt>=STARVE_LIM-1).
  - On that transition: latch len_q=npu_len (0 treated as 1), clear beat_cnt and starve_cnt.
  - The CPU access in that same cycle still completes.
- State BURST:
  - npu_gnt=1 (registered: asserts the cycle after the decision).
  - mem_* muxed from the NPU; npu_rdata=mem_rdata; cpu_rdata=0.
  - cpu_stall=cpu_act (combinational).
  - beat_cnt increments on each cycle with npu_rd|npu_wr. Idle NPU cycles are allowed and hold the grant.
  - Beat with beat_cnt==len_q-1: npu_done=1 that cycle; go to IDLE next edge.
  - npu_req deasserted during BURST: abort, go to IDLE next edge, no done. Any access that cycle is still performed.
- IDLE lasts at least one cycle after every BURST, so a stalled CPU is always served before the next NPU grant.
- npu_done is asserted only in BURST.
- Latency:
  - CPU access in IDLE: 0 cycles.
  - Worst-case CPU stall: len_q + idle NPU cycles (bounded by NPU behaviour).
  - Worst-case NPU wait: STARVE_LIM cycles plus 1.

Decomposition:
- Shared package holds:
  - the 1-bit state encoding (ARB_IDLE, ARB_BURST);
  - default ADDR_W, DATA_W, LEN_W, STARVE_LIM constants;
  - the NOP-data constant 0.
- Single module; the mux/counter logic is too small to justify a sub-module.

Test Plan:
- Reset held, all requests active -> mem_rd=mem_wr=0, npu_gnt=0, cpu_stall=0. Release -> CPU load of addr 0x40 with mem_rdata=0x1234 gives cpu_rdata=0x1234 the same cycle.
- No CPU traffic, npu_req=1, npu_len=4, 4 consecutive writes -> npu_gnt rises the next cycle, 4 mem_wr pulses with NPU addr/data, npu_done on the 4th beat, npu_gnt=0 after it.
- CPU store every cycle plus npu_req, STARVE_LIM=16 -> 16 CPU stores complete, then npu_gnt=1. A CPU store during the burst sees cpu_stall=1 and completes in the first IDLE cycle after done.
- npu_len=0 -> exactly one beat, npu_done on that beat.
- Burst len=8, npu_req dropped after 3 beats -> return to IDLE, no npu_done, beat_cnt cleared on the next grant.
- rst asserted mid-burst (beat 2 of 5) -> npu_gnt=0 and mem_wr=0 immediately; after release the state is IDLE and the CPU is served.
